regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 74 +++++++
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Source index constants double as bit positions in the per-source head/grant vectors.
package wb_pkg;

  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_NUM_SRC    = 2;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'h1 << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry write-back request queue with 1-bit wrap pointers and a 2-bit occupancy count.
// Push is refused when full, even on a cycle that also pops; rd_mask_o exists only with WB_SCOREBOARD_EN.
module wb_fifo
  import wb_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  logic [4:0]  push_rd_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
`ifdef WB_SCOREBOARD_EN
  output logic [31:0] rd_mask_o,
`endif
  output logic        full_o,
  output logic        empty_o,
  output logic [4:0]  head_rd_o,
  output logic [31:0] head_data_o
);

  wb_req_t    mem_q [WB_FIFO_DEPTH];
  logic       rptr_q, rptr_d;
  logic       wptr_q, wptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o      = (count_q == 2'(WB_FIFO_DEPTH));
  assign empty_o     = (count_q == 2'd0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign head_rd_o   = mem_q[rptr_q].rd;
  assign head_data_o = mem_q[rptr_q].data;

  // With two entries, advancing a 1-bit pointer is a toggle.
  always_comb begin
    rptr_d  = rptr_q ^ do_pop;
    wptr_d  = wptr_q ^ do_push;
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= '{rd: push_rd_i, data: push_data_i};
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [WB_FIFO_DEPTH-1:0] ent_vld;

  always_comb begin
    ent_vld[0] = (count_q == 2'd2) || ((count_q == 2'd1) && !rptr_q);
    ent_vld[1] = (count_q == 2'd2) || ((count_q == 2'd1) && rptr_q);
    rd_mask_o  = '0;
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      if (ent_vld[i]) begin
        rd_mask_o = rd_mask_o | rd_onehot(mem_q[i].rd);
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU and load-unit write-backs onto one registered register-file write port.
// Optional WB_SCOREBOARD_EN adds the combinational pending-write mask; otherwise pending is tied low.
module regfile_wb_arbiter
  import wb_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        Load,
  output logic [4:0]  addrD,
  output logic [31:0] D,
  output logic [31:0] pending
);

  logic                  alu_full, alu_empty, mem_full, mem_empty;
  logic                  alu_push, mem_push;
  logic [4:0]            alu_head_rd, mem_head_rd;
  logic [31:0]           alu_head_data, mem_head_data;
  logic [WB_NUM_SRC-1:0] head_vld, grant;

  logic                  prio_q, prio_d;
  logic                  load_q, load_d;
  logic [4:0]            addrd_q, addrd_d;
  logic [31:0]           d_q, d_d;

`ifdef WB_SCOREBOARD_EN
  logic [31:0]           alu_mask, mem_mask, inflight;
`endif

  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  // x0 writes complete the handshake but never enter a queue.
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);

  wb_fifo u_alu_fifo (
    .clk_i       (Clk),
    .reset_i     (Reset),
    .push_i      (alu_push),
    .push_rd_i   (alu_rd),
    .push_data_i (alu_data),
    .pop_i       (grant[SRC_ALU]),
`ifdef WB_SCOREBOARD_EN
    .rd_mask_o   (alu_mask),
`endif
    .full_o      (alu_full),
    .empty_o     (alu_empty),
    .head_rd_o   (alu_head_rd),
    .head_data_o (alu_head_data)
  );

  wb_fifo u_mem_fifo (
    .clk_i       (Clk),
    .reset_i     (Reset),
    .push_i      (mem_push),
    .push_rd_i   (mem_rd),
    .push_data_i (mem_data),
    .pop_i       (grant[SRC_MEM]),
`ifdef WB_SCOREBOARD_EN
    .rd_mask_o   (mem_mask),
`endif
    .full_o      (mem_full),
    .empty_o     (mem_empty),
    .head_rd_o   (mem_head_rd),
    .head_data_o (mem_head_data)
  );

  always_comb begin
    head_vld          = '0;
    head_vld[SRC_ALU] = !alu_empty;
    head_vld[SRC_MEM] = !mem_empty;
  end

  // Priority only moves when both heads compete.
  always_comb begin
    grant  = '0;
    prio_d = prio_q;
    if (&head_vld) begin
      grant[prio_q] = 1'b1;
      prio_d        = ~prio_q;
    end else begin
      grant = head_vld;
    end
  end

  always_comb begin
    load_d  = |grant;
    addrd_d = addrd_q;
    d_d     = d_q;
    if (grant[SRC_ALU]) begin
      addrd_d = alu_head_rd;
      d_d     = alu_head_data;
    end else if (grant[SRC_MEM]) begin
      addrd_d = mem_head_rd;
      d_d     = mem_head_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prio_q  <= SRC_ALU;
      load_q  <= 1'b0;
      addrd_q <= 5'd0;
      d_q     <= 32'd0;
    end else begin
      prio_q  <= prio_d;
      load_q  <= load_d;
      addrd_q <= addrd_d;
      d_q     <= d_d;
    end
  end

  assign Load  = load_q;
  assign addrD = addrd_q;
  assign D     = d_q;

`ifdef WB_SCOREBOARD_EN
  assign inflight = load_q ? rd_onehot(addrd_q) : 32'd0;
  assign pending  = (alu_mask | mem_mask | inflight) & ~32'h1;
`else
  assign pending  = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; pending expectations follow WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;

  logic        Clk;
  logic        Reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        Load;
  logic [4:0]  addrD;
  logic [31:0] D;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  // Expected write address / pending mask after each contention edge.
  int          cont_rd   [10] = '{0, 1, 11, 2, 12, 3, 13, 4, 14, 0};
  logic [31:0] cont_pend [10] = '{32'h0802, 32'h1806, 32'h180C, 32'h300C, 32'h3018,
                                  32'h6018, 32'h6010, 32'h4010, 32'h4000, 32'h0000};

  regfile_wb_arbiter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .Load      (Load),
    .addrD     (addrD),
    .D         (D),
    .pending   (pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef WB_SCOREBOARD_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  initial begin
    int ai, mi;
    logic af, mf;
    logic [31:0] exp_d;

    Reset = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    step();
    step();
    Reset = 1'b0;
    check("rst_load",    32'(Load),      32'd0);
    check("rst_addrD",   32'(addrD),     32'd0);
    check("rst_D",       D,              32'd0);
    check("rst_pending", pending,        32'd0);
    check("rst_alu_rdy", 32'(alu_ready), 32'd1);
    check("rst_mem_rdy", 32'(mem_ready), 32'd1);

    // Single ALU write: accepted at edge 1, Load after edge 2 only.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check("t1_e1_load",  32'(Load), 32'd0);
    check("t1_e1_pend",  pending,   pexp(32'h20));
    step();
    check("t1_e2_load",  32'(Load),  32'd1);
    check("t1_e2_addrD", 32'(addrD), 32'd5);
    check("t1_e2_D",     D,          32'hDEADBEEF);
    check("t1_e2_pend",  pending,    pexp(32'h20));
    step();
    check("t1_e3_load",  32'(Load),  32'd0);
    check("t1_e3_addrD", 32'(addrD), 32'd5);
    check("t1_e3_D",     D,          32'hDEADBEEF);
    check("t1_e3_pend",  pending,    32'd0);

    // x0 write: handshake completes, nothing is written.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
    check("x0_ready", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    check("x0_e1_load", 32'(Load), 32'd0);
    check("x0_e1_pend", pending,   32'd0);
    step();
    check("x0_e2_load", 32'(Load), 32'd0);
    check("x0_e2_pend", pending,   32'd0);
    step();
    check("x0_e3_load",  32'(Load),  32'd0);
    check("x0_e3_addrD", 32'(addrD), 32'd5);

    // Backpressure: MEM queue fills while the ALU wins the first grant.
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h0000_0A21;
    mem_valid = 1'b1; mem_rd = 5'd22; mem_data = 32'h0000_0B01;
    check("bp_p0_mrdy", 32'(mem_ready), 32'd1);
    step();
    alu_rd = 5'd23; alu_data = 32'h0000_0A22;
    mem_rd = 5'd24; mem_data = 32'h0000_0B02;
    check("bp_p1_mrdy", 32'(mem_ready), 32'd1);
    check("bp_p1_load", 32'(Load),      32'd0);
    step();
    alu_valid = 1'b0;
    mem_rd = 5'd25; mem_data = 32'h0000_0B03;
    check("bp_p2_mrdy",  32'(mem_ready), 32'd0);
    check("bp_p2_addrD", 32'(addrD),     32'd21);
    check("bp_p2_D",     D,              32'h0000_0A21);
    check("bp_p2_pend",  pending,        pexp(32'h01E0_0000));
    step();
    check("bp_p3_mrdy",  32'(mem_ready), 32'd1);
    check("bp_p3_load",  32'(Load),      32'd1);
    check("bp_p3_addrD", 32'(addrD),     32'd22);
    check("bp_p3_D",     D,              32'h0000_0B01);
    step();
    mem_valid = 1'b0;
    check("bp_p4_addrD", 32'(addrD), 32'd23);
    check("bp_p4_D",     D,          32'h0000_0A22);
    step();
    check("bp_p5_addrD", 32'(addrD), 32'd24);
    check("bp_p5_D",     D,          32'h0000_0B02);
    step();
    check("bp_p6_load",  32'(Load),  32'd1);
    check("bp_p6_addrD", 32'(addrD), 32'd25);
    check("bp_p6_D",     D,          32'h0000_0B03);
    check("bp_p6_pend",  pending,    pexp(32'h0200_0000));
    step();
    check("bp_p7_load",  32'(Load), 32'd0);
    check("bp_p7_pend",  pending,   32'd0);

    // Reset with queued entries and a registered write in flight.
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0006;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_0007;
    step();
    alu_rd = 5'd8; alu_data = 32'h0000_0008;
    mem_rd = 5'd9; mem_data = 32'h0000_0009;
    step();
    check("mr_pre_load",  32'(Load),      32'd1);
    check("mr_pre_addrD", 32'(addrD),     32'd7);
    check("mr_pre_ardy",  32'(alu_ready), 32'd0);
    check("mr_pre_pend",  pending,        pexp(32'h0000_03C0));
    alu_rd = 5'd10; mem_rd = 5'd17;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("mr_load",  32'(Load),      32'd0);
    check("mr_addrD", 32'(addrD),     32'd0);
    check("mr_D",     D,              32'd0);
    check("mr_pend",  pending,        32'd0);
    check("mr_ardy",  32'(alu_ready), 32'd1);
    check("mr_mrdy",  32'(mem_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mr_post%0d_load", k), 32'(Load), 32'd0);
      check($sformatf("mr_post%0d_pend", k), pending,   32'd0);
    end

    // Contention: both sources streaming, valid held until accepted.
    ai = 0; mi = 0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = (ai < 4); alu_rd = 5'(ai + 1);  alu_data = 32'h100 + 32'(ai);
      mem_valid = (mi < 4); mem_rd = 5'(mi + 11); mem_data = 32'h200 + 32'(mi);
      af = alu_valid && alu_ready;
      mf = mem_valid && mem_ready;
      step();
      if (af) ai++;
      if (mf) mi++;
      check($sformatf("ct%0d_load", c), 32'(Load), (cont_rd[c] != 0) ? 32'd1 : 32'd0);
      if (cont_rd[c] != 0) begin
        exp_d = (cont_rd[c] < 11) ? 32'h100 + 32'(cont_rd[c] - 1) : 32'h200 + 32'(cont_rd[c] - 11);
        check($sformatf("ct%0d_addrD", c), 32'(addrD), 32'(cont_rd[c]));
        check($sformatf("ct%0d_D", c),     D,          exp_d);
      end
      check($sformatf("ct%0d_pend", c), pending, pexp(cont_pend[c]));
    end
    check("ct_alu_sent", 32'(ai), 32'd4);
    check("ct_mem_sent", 32'(mi), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
